// File: rtl/sram_arbiter_if.sv
// Requester-side handshake bundle for sram_arbiter: the read port (VGA scan-out) and the write port (camera writer).
interface sram_arbiter_if;
    logic        rd_req;
    logic [17:0] rd_addr;
    logic        rd_gnt;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        wr_req;
    logic [17:0] wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_be;
    logic        wr_gnt;

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
        input  rd_gnt, rd_valid, rd_data, wr_gnt
    );

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
        output rd_gnt, rd_valid, rd_data, wr_gnt
    );
endinterface

// File: rtl/sram_arbiter.sv
// Read-priority arbiter and strobe sequencer for the 256Kx16 async SRAM.
// Optional grant statistics counters are built when SRAM_ARB_STATS_EN is defined.
//
// state       | meaning
// ST_IDLE     | strobes inactive, arbitration on current requests
// ST_RD       | CE/OE/UB/LB low for RD_WAIT cycles, data captured on last cycle
// ST_WR_SETUP | CE low, address/byte enables/data valid, WE high
// ST_WR_PULSE | WE low for WR_WAIT cycles
// ST_WR_HOLD  | WE high again, data still driven
module sram_arbiter #(
    parameter int RD_WAIT      = 2,
    parameter int WR_WAIT      = 2,
    parameter int MAX_RD_BURST = 8
) (
    input  logic          CLK,
    input  logic          RST_N,
    sram_arbiter_if.slave bus,
    output logic          busy,
    output logic [15:0]   stat_rd_cnt,
    output logic [15:0]   stat_wr_cnt,
    output logic [17:0]   SRAM_ADDR,
    inout  wire  [15:0]   SRAM_DQ,
    output logic          SRAM_CE_N,
    output logic          SRAM_OE_N,
    output logic          SRAM_WE_N,
    output logic          SRAM_UB_N,
    output logic          SRAM_LB_N
);
    localparam int WMAX = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int CW   = $clog2(WMAX + 1);
    localparam int SW   = $clog2(MAX_RD_BURST + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_RD_BURST);

    typedef enum logic [2:0] {
        ST_IDLE, ST_RD, ST_WR_SETUP, ST_WR_PULSE, ST_WR_HOLD
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_wait_cnt, w_cnt_nxt;
    logic [SW-1:0]   r_starve_cnt;
    logic            w_rd_win, w_wr_win, w_capture;
    logic            r_rd_gnt, r_wr_gnt, r_rd_valid;
    logic [15:0]     r_rd_data, r_dq_out;
    logic [1:0]      r_be, w_be_nxt;
    logic            r_dq_oe, w_dq_oe;
    logic            r_ce_n, r_oe_n, r_we_n, r_ub_n, r_lb_n;
    logic            w_ce_n, w_oe_n, w_we_n, w_ub_n, w_lb_n;

    always_ff @(posedge CLK) begin
        if (!RST_N) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_wait_cnt;
        w_rd_win    = 1'b0;
        w_wr_win    = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.rd_req && bus.wr_req) begin
                    if (r_starve_cnt >= STARVE_MAX) w_wr_win = 1'b1;
                    else                            w_rd_win = 1'b1;
                end else if (bus.rd_req) begin
                    w_rd_win = 1'b1;
                end else if (bus.wr_req) begin
                    w_wr_win = 1'b1;
                end
                if (w_rd_win) begin
                    w_state_nxt = ST_RD;
                    w_cnt_nxt   = CW'(RD_WAIT - 1);
                end else if (w_wr_win) begin
                    w_state_nxt = ST_WR_SETUP;
                end
            end
            ST_RD: begin
                if (r_wait_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                    w_capture   = 1'b1;
                end else begin
                    w_cnt_nxt = r_wait_cnt - CW'(1);
                end
            end
            ST_WR_SETUP: begin
                w_state_nxt = ST_WR_PULSE;
                w_cnt_nxt   = CW'(WR_WAIT - 1);
            end
            ST_WR_PULSE: begin
                if (r_wait_cnt == '0) w_state_nxt = ST_WR_HOLD;
                else                  w_cnt_nxt   = r_wait_cnt - CW'(1);
            end
            ST_WR_HOLD: w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase

        // Strobes are registered from the next state so they line up with the state itself.
        w_be_nxt = w_wr_win ? bus.wr_be : r_be;
        w_ce_n   = (w_state_nxt == ST_IDLE);
        w_oe_n   = (w_state_nxt != ST_RD);
        w_we_n   = (w_state_nxt != ST_WR_PULSE);
        w_dq_oe  = (w_state_nxt == ST_WR_SETUP) || (w_state_nxt == ST_WR_PULSE) ||
                   (w_state_nxt == ST_WR_HOLD);
        if (w_state_nxt == ST_IDLE) begin
            w_ub_n = 1'b1;
            w_lb_n = 1'b1;
        end else if (w_state_nxt == ST_RD) begin
            w_ub_n = 1'b0;
            w_lb_n = 1'b0;
        end else begin
            w_ub_n = ~w_be_nxt[1];
            w_lb_n = ~w_be_nxt[0];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_wait_cnt   <= '0;
            r_starve_cnt <= '0;
            r_rd_gnt     <= 1'b0;
            r_wr_gnt     <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_data    <= '0;
            r_dq_out     <= '0;
            r_be         <= '0;
            r_dq_oe      <= 1'b0;
            r_ce_n       <= 1'b1;
            r_oe_n       <= 1'b1;
            r_we_n       <= 1'b1;
            r_ub_n       <= 1'b1;
            r_lb_n       <= 1'b1;
            SRAM_ADDR    <= '0;
        end else begin
            r_wait_cnt <= w_cnt_nxt;
            r_rd_gnt   <= w_rd_win;
            r_wr_gnt   <= w_wr_win;
            r_rd_valid <= w_capture;
            if (w_capture) r_rd_data <= SRAM_DQ;
            r_be    <= w_be_nxt;
            r_dq_oe <= w_dq_oe;
            r_ce_n  <= w_ce_n;
            r_oe_n  <= w_oe_n;
            r_we_n  <= w_we_n;
            r_ub_n  <= w_ub_n;
            r_lb_n  <= w_lb_n;
            if (w_rd_win) begin
                SRAM_ADDR <= bus.rd_addr;
                if (!bus.wr_req)                    r_starve_cnt <= '0;
                else if (r_starve_cnt < STARVE_MAX) r_starve_cnt <= r_starve_cnt + SW'(1);
            end else if (w_wr_win) begin
                SRAM_ADDR    <= bus.wr_addr;
                r_dq_out     <= bus.wr_data;
                r_starve_cnt <= '0;
            end
        end
    end

`ifdef SRAM_ARB_STATS_EN
    logic [15:0] r_stat_rd, r_stat_wr;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_stat_rd <= '0;
            r_stat_wr <= '0;
        end else begin
            if (r_rd_gnt && (r_stat_rd != 16'hFFFF)) r_stat_rd <= r_stat_rd + 16'd1;
            if (r_wr_gnt && (r_stat_wr != 16'hFFFF)) r_stat_wr <= r_stat_wr + 16'd1;
        end
    end

    assign stat_rd_cnt = r_stat_rd;
    assign stat_wr_cnt = r_stat_wr;
`else
    assign stat_rd_cnt = '0;
    assign stat_wr_cnt = '0;
`endif

    assign SRAM_DQ      = r_dq_oe ? r_dq_out : 16'bz;
    assign SRAM_CE_N    = r_ce_n;
    assign SRAM_OE_N    = r_oe_n;
    assign SRAM_WE_N    = r_we_n;
    assign SRAM_UB_N    = r_ub_n;
    assign SRAM_LB_N    = r_lb_n;
    assign busy         = (r_state != ST_IDLE);
    assign bus.rd_gnt   = r_rd_gnt;
    assign bus.wr_gnt   = r_wr_gnt;
    assign bus.rd_valid = r_rd_valid;
    assign bus.rd_data  = r_rd_data;
endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Two-port arbiter and timing sequencer for the board's 256Kx16 asynchronous SRAM.
- Shares the SRAM between the camera frame writer (write port) and the VGA scan-out reader (read port). Both sit in the video processing path.
- Reads have priority because they carry the display deadline. A burst limit stops writes from starving.
- Generates all SRAM strobes and owns the SRAM_DQ tristate.

Parameters:
- RD_WAIT, 2, cycles OE_N is held low before read data is captured (>=1).
- WR_WAIT, 2, cycles WE_N is held low per write (>=1).
- MAX_RD_BURST, 8, consecutive read grants allowed while a write is pending before the write is forced (>=1).

Ports:
- CLK  in  1  system clock (50 MHz).
- RST_N  in  1  reset, synchronous, active-low.
- rd_req  in  1  read request; held with rd_addr stable until rd_gnt.
- rd_addr  in  18  read word address.
- rd_gnt  out  1  one-cycle pulse; read request accepted.
- rd_valid  out  1  one-cycle pulse; rd_data is valid.
- rd_data  out  16  read data; held until the next capture.
- wr_req  in  1  write request; held with wr_addr/wr_data/wr_be stable until wr_gnt.
- wr_addr  in  18  write word address.
- wr_data  in  16  write data.
- wr_be  in  2  byte enables, active-high: [1]=upper byte, [0]=lower byte.
- wr_gnt  out  1  one-cycle pulse; write request accepted.
- busy  out  1  high whenever the state is not IDLE.
- stat_rd_cnt  out  16  read-grant counter (optional feature).
- stat_wr_cnt  out  16  write-grant counter (optional feature).
- SRAM_ADDR  out  18  SRAM address, registered.
- SRAM_DQ  inout  16  SRAM data bus.
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  SRAM strobes, registered, active-low.

Behaviour:
- Reset (RST_N=0 sampled at a rising edge):
  - state=IDLE; rd_gnt=wr_gnt=rd_valid=0; rd_data=0; SRAM_ADDR=0.
  - All SRAM strobes =1; SRAM_DQ=Z; starve_cnt=0; stats=0.
  - Reset mid-transaction aborts at the next edge. No rd_valid is issued. A truncated write may leave the target word undefined.
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD.
- Arbitration happens only in IDLE, combinationally on the requests present that cycle. The gnt pulse is registered, so it is high in the first cycle of the new state.
  - Both requests high: write wins if starve_cnt >= MAX_RD_BURST, otherwise read wins.
  - Only one request high: that request wins.
  - Neither high: stay in IDLE.
- starve_cnt updates at each grant:
  - Read grant with wr_req=1: increment, saturating at MAX_RD_BURST.
  - Read grant with wr_req=0: clear.
  - Any write grant: clear.
- Requesters must sample gnt and may change their request signals the cycle after gnt. The arbiter has already latched address, data and byte enables. The arbiter never re-grants a request that is still held in the cycle gnt is high, because it is not in IDLE that cycle.
- Read sequence, with the grant decision in IDLE at cycle T:
  - RD for cycles T+1..T+RD_WAIT: CE_N=0, OE_N=0, UB_N=LB_N=0, WE_N=1, SRAM_ADDR=latched address, DQ=Z.
  - SRAM_DQ is sampled into rd_data at the end of T+RD_WAIT.
  - rd_valid=1 in T+RD_WAIT+1, when the state is back in IDLE.
  - Back-to-back read issue interval: RD_WAIT+1 cycles.
- Write sequence:
  - WR_SETUP (1 cycle): CE_N=0, OE_N=1, WE_N=1, address and byte enables valid, DQ driven.
  - WR_PULSE (WR_WAIT cycles): WE_N=0.
  - WR_HOLD (1 cycle): WE_N=1, DQ still driven.
  - Then IDLE. Issue interval: WR_WAIT+3 cycles.
- UB_N=~wr_be[1], LB_N=~wr_be[0] during a write. wr_be=2'b00 still runs the full sequence with both bytes masked.
- The DQ drive enable is registered and high only in WR_SETUP, WR_PULSE and WR_HOLD. OE_N is never 0 while DQ is driven.
- IDLE: CE_N=OE_N=WE_N=UB_N=LB_N=1; DQ=Z; SRAM_ADDR holds its last value.
- Address arithmetic: none. Addresses pass through unchanged; there is no wrap handling inside the block.

Optional Feature:
- SRAM_ARB_STATS_EN defined:
  - stat_rd_cnt increments by 1 on each rd_gnt; stat_wr_cnt increments by 1 on each wr_gnt.
  - Both are 16-bit, saturating at 16'hFFFF, and cleared by reset.
- Macro undefined: both ports are constant 0 and no counter logic is built.

Test Plan:
- Single read, rd_addr=18'h00123, SRAM model returns 16'hBEEF, RD_WAIT=2 -> rd_gnt at T+1; OE_N low in T+1..T+2; rd_valid=1 with rd_data=16'hBEEF at T+3.
- Single write, wr_addr=18'h3FFFF, wr_data=16'hA55A, wr_be=2'b01 -> WE_N low for exactly 2 cycles; UB_N=1, LB_N=0; DQ driven for 4 cycles; model lower byte =8'h5A, upper byte unchanged.
- rd_req and wr_req held high continuously, MAX_RD_BURST=8 -> grant pattern 8 reads, 1 write, repeating; wr_gnt never absent for more than 8 consecutive read grants.
- Read issued immediately after a write -> DQ returns to Z in the IDLE cycle before OE_N goes 0; no cycle has OE_N=0 while DQ is driven.
- RST_N driven 0 during WR_PULSE -> next edge: WE_N=1, CE_N=1, DQ=Z, busy=0; no gnt or rd_valid pulses until new requests arrive after reset release.
- With SRAM_ARB_STATS_EN, 5 reads and 3 writes -> stat_rd_cnt=5, stat_wr_cnt=3. Without the macro -> both stay 0.
